debruijn_shift_gen: RTL and testbench
=====================================

Name: debruijn_shift_gen

Overview:
- Parametrised shift-register sequence generator that produces a de Bruijn sequence of order WIDTH, with period exactly 2^WIDTH and the all-zero state included.
- Built as a Fibonacci LFSR with zero-state insertion.
- Provides seed load, step enable, a one-cycle wrap pulse when the sequence returns to its start point, and an optional period checker.
- Serves as the stimulus/pattern source for the de-bruijn subsystem, in place of chains of single DFF stages.

Parameters:
- WIDTH, 4, register order; legal range 2..32; sequence period is 2^WIDTH.
- TAPS, 4'b1001, feedback mask of WIDTH bits. Must describe a primitive polynomial and must have TAPS[WIDTH-1]=1; the generator does not check this.
- SEED, 1, value loaded into state and anchor on reset; any WIDTH-bit value is legal, zero included.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  advance the sequence one step this cycle.
- load  in  1  load load_val as the new state and anchor.
- load_val  in  WIDTH  value used by load.
- state  out  WIDTH  current register contents.
- bit_out  out  1  serial de Bruijn output, equal to state[WIDTH-1].
- wrap  out  1  registered one-cycle pulse when a step returns state to the anchor.
- err  out  1  sticky period-mismatch flag; tied to 0 unless DEBRUIJN_CHECK_EN is defined.

Behaviour:
- Priority per rising edge: rst > load > en > hold.
- rst:
  - state <= SEED, anchor <= SEED, wrap <= 0, err <= 0.
  - Step counter <= 0 when the checker is present.
- load:
  - state <= load_val, anchor <= load_val, wrap <= 0, counter <= 0.
  - en is ignored in the same cycle. err is not cleared by load.
- en step:
  - fb = XOR-reduce(state & TAPS) XOR (state[WIDTH-2:0] == 0).
  - state <= {state[WIDTH-2:0], fb}.
  - This inserts the zero state: {1,0...0} -> 0, and 0 -> 1. All 2^WIDTH values are visited once per period.
- wrap:
  - wrap <= 1 in the cycle after an en step whose next state equals anchor; otherwise wrap <= 0.
  - Hence wrap is high for exactly one cycle, together with state == anchor.
  - Holding (en=0) never asserts wrap, even while state == anchor.
- Latency:
  - state and bit_out change on the edge that samples en=1.
  - wrap is aligned with the new state; no extra pipeline stage.
- No lockup: zero is a normal state, so no recovery logic is needed.
- Reset mid-sequence: the next cycle shows SEED with wrap=0; the partial period is discarded.
- Load of the value already held: the anchor is re-armed and a full 2^WIDTH steps are needed before wrap.
- Simultaneous load and en: the load wins; the step is lost.

Optional Feature:
- Macro: DEBRUIJN_CHECK_EN.
- When defined:
  - A WIDTH-bit step counter increments (mod 2^WIDTH) on every en step.
  - It is cleared by rst and by load.
  - On a step whose next state equals anchor, the counter must be rolling to 0, i.e. currently all ones. If it is not, err <= 1.
  - err is sticky until rst.
  - A counter rollover without a matching wrap also sets err.
- When not defined: no counter is built and err is constant 0.

Test Plan:
- Reset with default parameters (WIDTH=4, TAPS=4'b1001, SEED=1): rst=1 for 2 cycles -> state=0001, bit_out=0, wrap=0, err=0.
- Continuous en from 0001 -> state sequence 0011,0111,1111,1110,1101,1010,0101,1011,0110,1100,1001,0010,0100,1000,0000,0001:
  - wrap=1 only on the 16th step, with state=0001.
  - The bit_out stream contains every 4-bit window once per period.
- en toggled 1/0 alternately for 32 cycles -> state advances only on en=1 cycles; wrap never asserts during holds; wrap pulses once after the 16th step.
- load=1, load_val=0000 at step 5, en=1 in the same cycle -> state=0000, en ignored:
  - The next steps give 0001, 0011, ...
  - wrap fires on the step returning to 0000, 16 steps later.
- rst asserted at step 7 with en=1 -> state=0001, wrap=0 the next cycle; the sequence restarts from 0011.
- With DEBRUIJN_CHECK_EN and a non-primitive TAPS=4'b1111:
  - Run 40 steps -> err=1 by the first premature wrap or unmatched rollover, and stays 1.
  - With the default TAPS, 64 steps -> err=0.

Source files
------------

// File: rtl/debruijn_shift_gen.sv
// De Bruijn sequence generator: Fibonacci LFSR with zero-state insertion, period 2^WIDTH.
// Define DEBRUIJN_CHECK_EN to build the step counter that flags period mismatches on err.
module debruijn_shift_gen #(
    parameter int unsigned      WIDTH = 4,
    parameter logic [WIDTH-1:0] TAPS  = 4'b1001,
    parameter logic [WIDTH-1:0] SEED  = {{(WIDTH-1){1'b0}}, 1'b1}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] state,
    output logic             bit_out,
    output logic             wrap,
    output logic             err
);

    logic [WIDTH-1:0] state_q, state_d;
    logic [WIDTH-1:0] anchor_q, anchor_d;
    logic             wrap_q, wrap_d;
    logic             fb;
    logic [WIDTH-1:0] step_state;
    logic             step_hit;

    // The zero-detect term splices 0 in between {1,0..0} and {0..0,1}.
    always_comb begin
        fb         = (^(state_q & TAPS)) ^ (state_q[WIDTH-2:0] == '0);
        step_state = {state_q[WIDTH-2:0], fb};
        step_hit   = (step_state == anchor_q);
    end

    always_comb begin
        state_d  = state_q;
        anchor_d = anchor_q;
        wrap_d   = 1'b0;
        if (load) begin
            state_d  = load_val;
            anchor_d = load_val;
        end else if (en) begin
            state_d = step_state;
            wrap_d  = step_hit;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= SEED;
            anchor_q <= SEED;
            wrap_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            anchor_q <= anchor_d;
            wrap_q   <= wrap_d;
        end
    end

`ifdef DEBRUIJN_CHECK_EN
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;

    // A return to the anchor must coincide exactly with the counter rolling over.
    always_comb begin
        cnt_d = cnt_q;
        err_d = err_q;
        if (load) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + WIDTH'(1);
            if (step_hit != (cnt_q == '1)) begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign state   = state_q;
    assign bit_out = state_q[WIDTH-1];
    assign wrap    = wrap_q;

endmodule

// File: tb/tb_debruijn_shift_gen.sv
// Directed bench for debruijn_shift_gen (WIDTH=4, TAPS=4'b1001, SEED=1).
// With DEBRUIJN_CHECK_EN a second instance with non-primitive taps exercises err.
module tb_debruijn_shift_gen;

    logic       clk = 1'b0;
    logic       rst, en, load;
    logic [3:0] load_val;
    logic [3:0] state;
    logic       bit_out, wrap, err;

    int checks   = 0;
    int failures = 0;

    logic [3:0]  seq [16];
    logic        bits [16];
    logic [15:0] seen;
    logic [3:0]  win;
    int          k;

    always #5 clk = ~clk;

    debruijn_shift_gen #(
        .WIDTH(4),
        .TAPS (4'b1001),
        .SEED (4'b0001)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .load    (load),
        .load_val(load_val),
        .state   (state),
        .bit_out (bit_out),
        .wrap    (wrap),
        .err     (err)
    );

`ifdef DEBRUIJN_CHECK_EN
    logic [3:0] state2;
    logic       bit_out2, wrap2, err2;

    debruijn_shift_gen #(
        .WIDTH(4),
        .TAPS (4'b1111),
        .SEED (4'b0001)
    ) dut_bad (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .load    (load),
        .load_val(load_val),
        .state   (state2),
        .bit_out (bit_out2),
        .wrap    (wrap2),
        .err     (err2)
    );
`endif

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input logic r, input logic e, input logic l, input logic [3:0] lv);
        rst      = r;
        en       = e;
        load     = l;
        load_val = lv;
        @(posedge clk);
        #1;
    endtask

    initial begin
        seq = '{4'b0011, 4'b0111, 4'b1111, 4'b1110, 4'b1101, 4'b1010, 4'b0101, 4'b1011,
                4'b0110, 4'b1100, 4'b1001, 4'b0010, 4'b0100, 4'b1000, 4'b0000, 4'b0001};

        // Reset
        cyc(1'b1, 1'b0, 1'b0, 4'h0);
        cyc(1'b1, 1'b0, 1'b0, 4'h0);
        check("rst_state", state, 4'b0001);
        check("rst_bit", bit_out, 1'b0);
        check("rst_wrap", wrap, 1'b0);
        check("rst_err", err, 1'b0);
`ifdef DEBRUIJN_CHECK_EN
        check("rst_err_bad", err2, 1'b0);
`endif

        // Continuous stepping over one full period
        for (int i = 1; i <= 16; i++) begin
            cyc(1'b0, 1'b1, 1'b0, 4'h0);
            check("run_state", state, seq[i-1]);
            check("run_bit", bit_out, seq[i-1][3]);
            check("run_wrap", wrap, i == 16);
            bits[i-1] = bit_out;
        end
        seen = '0;
        for (int i = 0; i < 16; i++) begin
            win = {bits[i], bits[(i+1)%16], bits[(i+2)%16], bits[(i+3)%16]};
            seen[win] = 1'b1;
        end
        check("windows", seen, 16'hffff);
        // Holding on the anchor must not pulse wrap
        cyc(1'b0, 1'b0, 1'b0, 4'h0);
        check("hold_state", state, 4'b0001);
        check("hold_wrap", wrap, 1'b0);
`ifdef DEBRUIJN_CHECK_EN
        check("bad_taps_err", err2, 1'b1);
`endif

        // Alternating enable
        k = 0;
        for (int c = 0; c < 32; c++) begin
            cyc(1'b0, (c % 2) == 0, 1'b0, 4'h0);
            if ((c % 2) == 0) k++;
            check("alt_state", state, seq[(k+15)%16]);
            check("alt_wrap", wrap, ((c % 2) == 0) && (k == 16));
        end

        // Load zero with en in the same cycle: load wins
        for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 1'b0, 4'h0);
        check("pre_load", state, 4'b1101);
        cyc(1'b0, 1'b1, 1'b1, 4'b0000);
        check("load_state", state, 4'b0000);
        check("load_wrap", wrap, 1'b0);
        for (int j = 1; j <= 16; j++) begin
            cyc(1'b0, 1'b1, 1'b0, 4'h0);
            check("ld0_state", state, seq[(j+14)%16]);
            check("ld0_wrap", wrap, j == 16);
        end

        // Reset mid-sequence with en high
        for (int i = 0; i < 7; i++) cyc(1'b0, 1'b1, 1'b0, 4'h0);
        check("pre_rst", state, 4'b1010);
        cyc(1'b1, 1'b1, 1'b0, 4'h0);
        check("midrst_state", state, 4'b0001);
        check("midrst_wrap", wrap, 1'b0);
        for (int j = 1; j <= 16; j++) begin
            cyc(1'b0, 1'b1, 1'b0, 4'h0);
            check("rst_run_state", state, seq[j-1]);
            check("rst_run_wrap", wrap, j == 16);
        end

        // Reload of the value already held re-arms a full period
        cyc(1'b0, 1'b0, 1'b1, 4'b0001);
        check("reload_state", state, 4'b0001);
        check("reload_wrap", wrap, 1'b0);
        for (int j = 1; j <= 16; j++) begin
            cyc(1'b0, 1'b1, 1'b0, 4'h0);
            check("reload_run_state", state, seq[j-1]);
            check("reload_run_wrap", wrap, j == 16);
        end

        check("final_err", err, 1'b0);
`ifdef DEBRUIJN_CHECK_EN
        check("final_err_bad", err2, 1'b1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
